// File: rtl/cnn_pkg.sv
// Shared constants and control-state encoding for the CNN front-end blocks.
package cnn_pkg;

    localparam int DATA_W  = 16;
    localparam int MAP_W   = 6;
    localparam int MAP_H   = 6;
    localparam int NUM_PIX = MAP_W * MAP_H;

    // Loader control states, reused by later control blocks.
    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } loader_state_e;

endpackage

// File: rtl/cnn_frame_loader.sv
// Assembles a raster-order pixel stream into a frame buffer, launches the
// accelerator with a one-cycle start pulse and holds the buffer until done
// or timeout.
module cnn_frame_loader #(
    parameter  int DATA_W  = cnn_pkg::DATA_W,
    parameter  int MAP_W   = cnn_pkg::MAP_W,
    parameter  int MAP_H   = cnn_pkg::MAP_H,
    parameter  int TIMEOUT = 255,
    localparam int NUM_PIX = MAP_W * MAP_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              acc_start,
    input  logic              acc_done,
    output logic [DATA_W-1:0] fmap_out [0:NUM_PIX-1],
    output logic              busy,
    output logic              frame_err,
    output logic              timeout_err,
    output logic [15:0]       frame_cnt
);
    import cnn_pkg::*;

    localparam int IDX_W = $clog2(NUM_PIX);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIX - 1);
    localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(TIMEOUT - 1);

    loader_state_e     state, state_nxt;
    logic [IDX_W-1:0]  wr_idx, idx_nxt;
    logic [TMR_W-1:0]  timer, tmr_nxt;
    logic              ferr_nxt, terr_nxt;
    logic [15:0]       cnt_nxt;
    logic              wr_en;
    logic [DATA_W-1:0] pix_buf [0:NUM_PIX-1];

    // Handshake and status outputs decode straight from the registered state.
    assign s_ready   = (state == FILL);
    assign acc_start = (state == START);
    assign busy      = (state == START) || (state == WAIT);
    assign fmap_out  = pix_buf;

    // Next-state, index, timer and flag update logic.
    always_comb begin
        state_nxt = state;
        idx_nxt   = wr_idx;
        tmr_nxt   = timer;
        ferr_nxt  = frame_err;
        terr_nxt  = timeout_err;
        cnt_nxt   = frame_cnt;
        wr_en     = 1'b0;
        case (state)
            FILL: begin
                if (s_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        // Full pixel count reached: launch even if s_last is missing.
                        state_nxt = START;
                        idx_nxt   = '0;
                        if (!s_last) ferr_nxt = 1'b1;
                    end else if (s_last) begin
                        // Short frame: drop it, keep stale pixels, restart fill.
                        ferr_nxt = 1'b1;
                        idx_nxt  = '0;
                    end else begin
                        idx_nxt = wr_idx + 1'b1;
                    end
                end
            end
            START: begin
                tmr_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                tmr_nxt = timer + 1'b1;
                // Done takes priority over a coincident timeout.
                if (acc_done) begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                    cnt_nxt   = frame_cnt + 16'd1;
                end else if (timer == TMR_END) begin
                    state_nxt = FILL;
                    idx_nxt   = '0;
                    terr_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = FILL;
                idx_nxt   = '0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            wr_idx      <= '0;
            timer       <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            wr_idx      <= idx_nxt;
            timer       <= tmr_nxt;
            frame_err   <= ferr_nxt;
            timeout_err <= terr_nxt;
            frame_cnt   <= cnt_nxt;
        end
    end

    // Frame buffer: written only in FILL, so it is stable through START/WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIX; i++) pix_buf[i] <= '0;
        end else if (wr_en) begin
            pix_buf[wr_idx] <= s_data;
        end
    end

endmodule
